// File: rtl/ppl_frame_dispatcher.sv
// Frame-level entry stage of the ray-marching ring: sequences frames, snapshots the
// camera pose and fills each ring slot with either a recirculated ray or a fresh pixel.
module ppl_frame_dispatcher #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int PREP_CYCLES = 4,
    parameter int SCAN_MODE   = 0,
    parameter int ADDR_W      = 17,
    parameter int PAY_W       = 256
) (
    input  logic                clk_ppl,
    input  logic                rst_n,
    input  logic                enable,
    input  logic signed [31:0]  p_pos_x,
    input  logic signed [31:0]  p_pos_y,
    input  logic signed [31:0]  p_pos_z,
    input  logic signed [31:0]  p_angle_x,
    input  logic signed [31:0]  p_angle_y,
    input  logic                ret_valid,
    input  logic                ret_done,
    input  logic [PAY_W-1:0]    ret_payload,
    output logic signed [31:0]  snap_pos_x,
    output logic signed [31:0]  snap_pos_y,
    output logic signed [31:0]  snap_pos_z,
    output logic signed [31:0]  snap_angle_x,
    output logic signed [31:0]  snap_angle_y,
    output logic                preparing,
    output logic                frame_start,
    output logic                frame_done,
    output logic                out_valid,
    output logic                out_new,
    output logic                out_last,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [15:0]         out_u,
    output logic [15:0]         out_v,
    output logic [PAY_W-1:0]    out_payload
);

    localparam int TOTAL  = H_RES * V_RES;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int PREP_W = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PREP, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [PREP_W-1:0]   prep_cnt, prep_cnt_nxt;
    logic [CNT_W-1:0]    issued, issued_nxt;
    logic [CNT_W-1:0]    inflight, inflight_nxt;
    logic [15:0]         x, x_nxt, y, y_nxt;
    logic [ADDR_W-1:0]   row_base, row_base_nxt;
    logic                recirc, ret_free, slot_open, issue, last_issue, start, done_now;

    always_ff @(posedge clk_ppl or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final PREP cycle already arbitrates the slot, so the first fresh pixel
    // leaves in the same cycle the state register shows RUN.
    always_comb begin
        state_nxt    = state;
        prep_cnt_nxt = prep_cnt;
        issued_nxt   = issued;
        x_nxt        = x;
        y_nxt        = y;
        row_base_nxt = row_base;
        start        = 1'b0;
        done_now     = 1'b0;

        recirc     = ret_valid && !ret_done;
        ret_free   = ret_valid && ret_done;
        slot_open  = (state == RUN) ||
                     ((state == PREP) && (prep_cnt == PREP_W'(PREP_CYCLES - 1)));
        issue      = slot_open && !recirc && enable && (issued < CNT_W'(TOTAL));
        last_issue = issue && (issued == CNT_W'(TOTAL - 1));

        unique case ({issue, ret_free})
            2'b10:   inflight_nxt = inflight + CNT_W'(1);
            2'b01:   inflight_nxt = inflight - CNT_W'(1);
            default: inflight_nxt = inflight;
        endcase

        if (issue) begin
            issued_nxt = issued + CNT_W'(1);
            if (x == 16'(H_RES - 1)) begin
                x_nxt = '0;
                if (SCAN_MODE == 1) begin
                    if (int'(y) + 2 < V_RES) begin
                        y_nxt        = y + 16'd2;
                        row_base_nxt = row_base + ADDR_W'(2 * H_RES);
                    end else begin
                        y_nxt        = 16'd1;
                        row_base_nxt = ADDR_W'(H_RES);
                    end
                end else begin
                    y_nxt        = y + 16'd1;
                    row_base_nxt = row_base + ADDR_W'(H_RES);
                end
            end else begin
                x_nxt = x + 16'd1;
            end
        end

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt    = PREP;
                    start        = 1'b1;
                    prep_cnt_nxt = '0;
                    issued_nxt   = '0;
                    x_nxt        = '0;
                    y_nxt        = '0;
                    row_base_nxt = '0;
                end
            end
            PREP: begin
                if (prep_cnt == PREP_W'(PREP_CYCLES - 1)) begin
                    prep_cnt_nxt = '0;
                    state_nxt    = last_issue ? DRAIN : RUN;
                end else begin
                    prep_cnt_nxt = prep_cnt + PREP_W'(1);
                end
            end
            RUN: begin
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight_nxt == '0) begin
                    state_nxt = IDLE;
                    done_now  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters and all outputs are registered from the decisions above.
    always_ff @(posedge clk_ppl or negedge rst_n) begin
        if (!rst_n) begin
            prep_cnt     <= '0;
            issued       <= '0;
            inflight     <= '0;
            x            <= '0;
            y            <= '0;
            row_base     <= '0;
            snap_pos_x   <= '0;
            snap_pos_y   <= '0;
            snap_pos_z   <= '0;
            snap_angle_x <= '0;
            snap_angle_y <= '0;
            preparing    <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            out_valid    <= 1'b0;
            out_new      <= 1'b0;
            out_last     <= 1'b0;
            out_addr     <= '0;
            out_u        <= '0;
            out_v        <= '0;
            out_payload  <= '0;
        end else begin
            prep_cnt     <= prep_cnt_nxt;
            issued       <= issued_nxt;
            inflight     <= inflight_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            row_base     <= row_base_nxt;
            if (start) begin
                snap_pos_x   <= p_pos_x;
                snap_pos_y   <= p_pos_y;
                snap_pos_z   <= p_pos_z;
                snap_angle_x <= p_angle_x;
                snap_angle_y <= p_angle_y;
            end
            preparing    <= (state_nxt == IDLE) || (state_nxt == PREP);
            frame_start  <= start;
            frame_done   <= done_now;
            out_valid    <= recirc || issue;
            out_new      <= issue;
            out_last     <= last_issue;
            out_addr     <= issue ? (row_base + ADDR_W'(x)) : '0;
            out_u        <= issue ? x : '0;
            out_v        <= issue ? y : '0;
            out_payload  <= recirc ? ret_payload : '0;
        end
    end

endmodule

// File: tb/tb_ppl_frame_dispatcher.sv
// Randomised self-checking bench: a delay-line ring feeds rays back to a 4x2 raster
// dispatcher checked against a pixel-list model; a 4x4 interleaved instance checks scan order.
module tb_ppl_frame_dispatcher;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int VB    = 4;
    localparam int PC    = 4;
    localparam int TOT   = H * V;
    localparam int TOT_B = H * VB;
    localparam int LAT   = 5;
    localparam int PW    = 64;

    logic clk_ppl = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b0;
    logic enable_b = 1'b1;
    logic signed [31:0] p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y;
    logic ret_valid, ret_done;
    logic [PW-1:0] ret_payload;
    logic ret_valid_b = 1'b0;
    logic ret_done_b  = 1'b0;
    logic [PW-1:0] ret_payload_b = '0;

    logic signed [31:0] a_snap_pos_x, a_snap_pos_y, a_snap_pos_z, a_snap_angle_x, a_snap_angle_y;
    logic a_preparing, a_frame_start, a_frame_done, a_out_valid, a_out_new, a_out_last;
    logic [2:0] a_out_addr;
    logic [15:0] a_out_u, a_out_v;
    logic [PW-1:0] a_out_payload;

    logic signed [31:0] b_snap_pos_x, b_snap_pos_y, b_snap_pos_z, b_snap_angle_x, b_snap_angle_y;
    logic b_preparing, b_frame_start, b_frame_done, b_out_valid, b_out_new, b_out_last;
    logic [3:0] b_out_addr;
    logic [15:0] b_out_u, b_out_v;
    logic [PW-1:0] b_out_payload;

    ppl_frame_dispatcher #(.H_RES(H), .V_RES(V), .PREP_CYCLES(PC), .SCAN_MODE(0),
                           .ADDR_W(3), .PAY_W(PW)) dut (
        .clk_ppl(clk_ppl), .rst_n(rst_n), .enable(enable),
        .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
        .p_angle_x(p_angle_x), .p_angle_y(p_angle_y),
        .ret_valid(ret_valid), .ret_done(ret_done), .ret_payload(ret_payload),
        .snap_pos_x(a_snap_pos_x), .snap_pos_y(a_snap_pos_y), .snap_pos_z(a_snap_pos_z),
        .snap_angle_x(a_snap_angle_x), .snap_angle_y(a_snap_angle_y),
        .preparing(a_preparing), .frame_start(a_frame_start), .frame_done(a_frame_done),
        .out_valid(a_out_valid), .out_new(a_out_new), .out_last(a_out_last),
        .out_addr(a_out_addr), .out_u(a_out_u), .out_v(a_out_v), .out_payload(a_out_payload)
    );

    ppl_frame_dispatcher #(.H_RES(H), .V_RES(VB), .PREP_CYCLES(PC), .SCAN_MODE(1),
                           .ADDR_W(4), .PAY_W(PW)) dut_b (
        .clk_ppl(clk_ppl), .rst_n(rst_n), .enable(enable_b),
        .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
        .p_angle_x(p_angle_x), .p_angle_y(p_angle_y),
        .ret_valid(ret_valid_b), .ret_done(ret_done_b), .ret_payload(ret_payload_b),
        .snap_pos_x(b_snap_pos_x), .snap_pos_y(b_snap_pos_y), .snap_pos_z(b_snap_pos_z),
        .snap_angle_x(b_snap_angle_x), .snap_angle_y(b_snap_angle_y),
        .preparing(b_preparing), .frame_start(b_frame_start), .frame_done(b_frame_done),
        .out_valid(b_out_valid), .out_new(b_out_new), .out_last(b_out_last),
        .out_addr(b_out_addr), .out_u(b_out_u), .out_v(b_out_v), .out_payload(b_out_payload)
    );

    always #5 clk_ppl = ~clk_ppl;

    int n_cmp = 0;
    int n_bad = 0;
    int order_a [TOT];
    int order_b [TOT_B];

    // Reference model: frame progress as a position in the pixel list plus an outstanding-ray count.
    int m_active, m_prep_left, m_next, m_out;
    logic signed [31:0] ms_px, ms_py, ms_pz, ms_ax, ms_ay;
    logic e_valid, e_new, e_last, e_prep, e_start, e_done;
    int e_addr, e_u, e_v;
    logic [PW-1:0] e_pay;

    logic [PW:0] ring [LAT];
    int b_cycle, first_new_cycle, first_new_addr, start_cycle, done_seen, frames_expected;
    int en_rand, en_fixed, max_pass, pose_rand, guard;
    logic signed [31:0] pose_x_req;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_active = 0; m_prep_left = 0; m_next = 0; m_out = 0;
        ms_px = '0; ms_py = '0; ms_pz = '0; ms_ax = '0; ms_ay = '0;
        e_valid = 0; e_new = 0; e_last = 0; e_prep = 0; e_start = 0; e_done = 0;
        e_addr = 0; e_u = 0; e_v = 0; e_pay = '0;
        for (int i = 0; i < LAT; i++) ring[i] = '0;
    endtask

    // Whatever leaves entry this cycle travels the ring and returns LAT cycles later;
    // the low nibble of the payload counts the passes still to march.
    task automatic applyStimulus();
        logic [PW:0] back;
        logic [PW-1:0] pay;
        back = ring[LAT-1];
        for (int i = LAT - 1; i > 0; i--) ring[i] = ring[i-1];
        if (e_valid && e_new) begin
            pay = {32'($urandom), 28'($urandom), 4'($urandom_range(0, max_pass))};
            ring[0] = {1'b1, pay};
        end else if (e_valid) begin
            pay = e_pay;
            pay[3:0] = pay[3:0] - 4'd1;
            ring[0] = {1'b1, pay};
        end else begin
            ring[0] = '0;
        end
        ret_valid   = back[PW];
        ret_done    = back[PW] && (back[3:0] == 4'd0);
        ret_payload = back[PW] ? back[PW-1:0] : {$urandom, $urandom};
        enable      = (en_rand != 0) ? ($urandom_range(0, 3) != 0) : (en_fixed != 0);
        if (pose_rand != 0) begin
            p_pos_x = $urandom; p_pos_y = $urandom; p_pos_z = $urandom;
            p_angle_x = $urandom; p_angle_y = $urandom;
        end else begin
            p_pos_x = pose_x_req;
        end
    endtask

    task automatic modelStep();
        logic recirc, freed, issue, drained;
        recirc  = ret_valid && !ret_done;
        freed   = ret_valid && ret_done;
        issue   = (m_active == 1) && (m_prep_left <= 1) && !recirc && enable && (m_next < TOT);
        drained = (m_active == 1) && (m_next == TOT);
        e_valid = recirc || issue;
        e_new   = issue;
        e_last  = issue && (m_next == TOT - 1);
        e_addr  = issue ? order_a[m_next] : 0;
        e_u     = issue ? e_addr % H : 0;
        e_v     = issue ? e_addr / H : 0;
        e_pay   = recirc ? ret_payload : '0;
        e_start = 0;
        e_done  = 0;
        m_out   = m_out + int'(issue) - int'(freed);
        if (issue) m_next++;
        if (m_active == 1) begin
            if (m_prep_left > 0) m_prep_left--;
            if (drained && m_out == 0) begin
                m_active = 0;
                e_done = 1;
            end
        end else if (enable) begin
            m_active = 1; m_prep_left = PC; m_next = 0; e_start = 1;
            ms_px = p_pos_x; ms_py = p_pos_y; ms_pz = p_pos_z; ms_ax = p_angle_x; ms_ay = p_angle_y;
        end
        e_prep = (m_active == 0) || (m_prep_left > 0);
    endtask

    task automatic cycleBody();
        logic bn;
        int ba;
        if (a_out_new && first_new_cycle == 0) begin
            first_new_cycle = b_cycle;
            first_new_addr  = int'(a_out_addr);
        end
        if (a_frame_start && start_cycle == 0) start_cycle = b_cycle;
        if (a_frame_done) done_seen++;
        if (e_done) frames_expected++;
        checkOutput("out_valid", a_out_valid, e_valid);
        checkOutput("out_new", a_out_new, e_new);
        checkOutput("out_last", a_out_last, e_last);
        checkOutput("out_addr", a_out_addr, e_addr);
        checkOutput("out_u", a_out_u, e_u);
        checkOutput("out_v", a_out_v, e_v);
        checkOutput("out_payload", a_out_payload, e_pay);
        checkOutput("preparing", a_preparing, e_prep);
        checkOutput("frame_start", a_frame_start, e_start);
        checkOutput("frame_done", a_frame_done, e_done);
        checkOutput("snap_pos_x", a_snap_pos_x, ms_px);
        checkOutput("snap_pos_y", a_snap_pos_y, ms_py);
        checkOutput("snap_pos_z", a_snap_pos_z, ms_pz);
        checkOutput("snap_angle_x", a_snap_angle_x, ms_ax);
        checkOutput("snap_angle_y", a_snap_angle_y, ms_ay);
        bn = (b_cycle >= PC + 2) && (b_cycle < PC + 2 + TOT_B);
        ba = 0;
        if (bn) ba = order_b[b_cycle - PC - 2];
        checkOutput("b_out_valid", b_out_valid, bn);
        checkOutput("b_out_new", b_out_new, bn);
        checkOutput("b_out_last", b_out_last, b_cycle == PC + 1 + TOT_B);
        checkOutput("b_out_addr", b_out_addr, ba);
        checkOutput("b_out_u", b_out_u, bn ? ba % H : 0);
        checkOutput("b_out_v", b_out_v, bn ? ba / H : 0);
        checkOutput("b_preparing", b_preparing, (b_cycle >= 2) && (b_cycle <= PC + 1));
        checkOutput("b_frame_start", b_frame_start, b_cycle == 2);
        checkOutput("b_frame_done", b_frame_done, 1'b0);
        applyStimulus();
        modelStep();
    endtask

    task automatic runCycle();
        @(posedge clk_ppl);
        #1;
        b_cycle++;
        cycleBody();
    endtask

    task automatic releaseReset();
        @(posedge clk_ppl);
        #1;
        rst_n = 1'b1;
        b_cycle = 1;
        first_new_cycle = 0;
        first_new_addr = -1;
        start_cycle = 0;
        cycleBody();
    endtask

    // Reset is asserted between clock edges so the outputs must clear without a clock.
    task automatic doReset();
        @(posedge clk_ppl);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", a_out_valid, 1'b0);
        checkOutput("rst_out_new", a_out_new, 1'b0);
        checkOutput("rst_out_addr", a_out_addr, 0);
        checkOutput("rst_preparing", a_preparing, 1'b0);
        checkOutput("rst_frame_done", a_frame_done, 1'b0);
        checkOutput("rst_snap_pos_x", a_snap_pos_x, 0);
        checkOutput("rst_b_out_valid", b_out_valid, 1'b0);
        modelReset();
        releaseReset();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++) order_a[yy * H + xx] = yy * H + xx;
        begin
            int k;
            k = 0;
            for (int pass = 0; pass < 2; pass++)
                for (int yy = pass; yy < VB; yy += 2)
                    for (int xx = 0; xx < H; xx++) begin
                        order_b[k] = yy * H + xx;
                        k++;
                    end
        end
        p_pos_x = 32'sd100; p_pos_y = -32'sd5; p_pos_z = 32'sd7;
        p_angle_x = 32'sd30; p_angle_y = -32'sd45;
        pose_x_req = 32'sd100;
        ret_valid = 1'b0; ret_done = 1'b0; ret_payload = '0;
        en_rand = 0; en_fixed = 1; max_pass = 0; pose_rand = 0;
        done_seen = 0; frames_expected = 0;
        modelReset();
        @(posedge clk_ppl);
        releaseReset();

        // First frame: start-up latency, pose hold and pose refresh on the next frame.
        while (b_cycle < 9) runCycle();
        pose_x_req = 32'sd200;
        while (b_cycle < 12) runCycle();
        checkOutput("frame_start_cycle", start_cycle, 2);
        checkOutput("first_fresh_cycle", first_new_cycle, PC + 2);
        checkOutput("first_fresh_addr", first_new_addr, 0);
        checkOutput("snap_hold_mid_frame", a_snap_pos_x, 32'sd100);
        guard = 0;
        while (frames_expected < 1 && guard < 60) begin
            runCycle();
            guard++;
        end
        repeat (3) runCycle();
        checkOutput("snap_next_frame", a_snap_pos_x, 32'sd200);

        // Random traffic: pauses, multi-pass rays, changing pose.
        en_rand = 1; max_pass = 2; pose_rand = 1;
        repeat (800) runCycle();

        // Clean restart, then abort a frame with three rays in flight.
        en_rand = 0; en_fixed = 1; max_pass = 0; pose_rand = 0;
        doReset();
        guard = 0;
        while (!(m_active == 1 && m_out == 3) && guard < 40) begin
            runCycle();
            guard++;
        end
        doReset();
        repeat (30) runCycle();
        checkOutput("restart_first_cycle", first_new_cycle, PC + 2);
        checkOutput("restart_first_addr", first_new_addr, 0);

        // Let everything drain with no new frames.
        en_fixed = 0; max_pass = 1;
        guard = 0;
        while (m_active == 1 && guard < 200) begin
            runCycle();
            guard++;
        end
        repeat (5) runCycle();
        checkOutput("frame_done_count", done_seen, frames_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
